// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch memory: fault bit positions,
// the NOP encoding returned on faulting fetches, and the response record
// carried through the read pipeline and response FIFO.
package imem_pkg;

  // Bit positions inside rsp_fault.
  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;
  localparam int FAULT_PARITY   = 2;
  localparam int FAULT_W        = 3;

  // Instruction word width carried in the response record.
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0]       RESET_PC = 32'h0000_0000;

  // One fetch response: instruction word plus its fault flags.
  typedef struct packed {
    logic [INST_W-1:0]  inst;
    logic [FAULT_W-1:0] fault;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO for the fetch unit. First-word fall-through:
// the head entry is visible combinationally while count is non-zero.
// clear empties the FIFO at the next edge and takes priority over push/pop.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  imem_rsp_t                  push_data,
  input  logic                       pop,
  output imem_rsp_t                  head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  imem_rsp_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  // Next-state for pointers and occupancy; a push into a full FIFO is only
  // taken when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Synchronous-read instruction memory for the pipelined fetch stage.
// Requests enter through a valid/ready port, flow through LATENCY read
// stages and land in a response FIFO sized so that backpressure can never
// overflow it. A program-load port writes words when the fetch side is idle.
// Optional feature macro: IMEM_PARITY_EN adds a stored even-parity bit per
// word and reports mismatches on rsp_fault bit 2.
//
// Handshake rule for every channel (req, rsp, ld): a transfer happens at a
// rising clk edge where valid and ready are both 1; valid must not depend on
// ready, and the payload is held stable while valid is high and ready is low.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_W-1:0]              rsp_inst,
  output logic [2:0]                     rsp_fault,
  input  logic                           flush,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [DATA_W-1:0]              ld_data
);

  localparam int FIFO_DEPTH = LATENCY + 1;
  localparam int IDX_W      = $clog2(DEPTH_WORDS);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W      = DATA_W + 1;
`else
  localparam int MEM_W      = DATA_W;
`endif

  logic [MEM_W-1:0] mem_q [DEPTH_WORDS];

  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             accept, pop, ld_accept;
  logic             misalign, out_of_range;
  logic [IDX_W-1:0] word_idx;
  logic [MEM_W-1:0] rd_word;
  imem_rsp_t        rd_rsp;
  logic             push_valid;
  imem_rsp_t        push_data;
  imem_rsp_t        fifo_head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Handshake decisions. Fetch wins over load: ld_ready drops whenever a
  // request is offered, and loads only proceed with nothing outstanding so
  // a later read of the same word never needs a bypass. req_ready depends
  // only on registered state and reset/flush/ld inputs, never on rsp_ready.
  always_comb begin
    ld_ready  = !reset && !flush && (outstanding_q == '0) && !req_valid;
    ld_accept = ld_valid && ld_ready;
    req_ready = !reset && !flush && !ld_accept &&
                (outstanding_q < CNT_W'(FIFO_DEPTH));
    accept    = req_valid && req_ready;
    rsp_valid = (fifo_count != '0);
    pop       = rsp_valid && rsp_ready && !flush;
    rsp_inst  = fifo_empty ? NOP_INST : fifo_head.inst;
    rsp_fault = fifo_empty ? '0 : fifo_head.fault;
  end

  // Address decode and array read; faulting fetches return a NOP.
  always_comb begin
    word_idx     = req_addr[IDX_W+1:2];
    misalign     = (req_addr[1:0] != 2'b00);
    out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
    rd_word      = mem_q[word_idx];
    rd_rsp.inst  = (misalign || out_of_range) ? NOP_INST : rd_word[DATA_W-1:0];
    rd_rsp.fault = '0;
    rd_rsp.fault[FAULT_MISALIGN] = misalign;
    rd_rsp.fault[FAULT_RANGE]    = out_of_range;
`ifdef IMEM_PARITY_EN
    // Stored word plus its parity bit must XOR to zero.
    rd_rsp.fault[FAULT_PARITY]   = !misalign && !out_of_range && (^rd_word);
`endif
  end

  // Program-load writes into the instruction array; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_accept) begin
`ifdef IMEM_PARITY_EN
      mem_q[ld_addr] <= {^ld_data, ld_data};
`else
      mem_q[ld_addr] <= ld_data;
`endif
    end
  end

  // Count of accepted requests not yet popped; bounds FIFO occupancy.
  always_comb begin
    outstanding_d = outstanding_q;
    if (flush) begin
      outstanding_d = '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
        2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Outstanding counter register.
  always_ff @(posedge clk) begin
    if (reset) outstanding_q <= '0;
    else       outstanding_q <= outstanding_d;
  end

  // Read pipeline. With LATENCY=1 the array read is written straight into
  // the FIFO at the accept edge; longer latencies add LATENCY-1 stages that
  // always advance, since the FIFO has room for everything in flight.
  if (LATENCY == 1) begin : g_lat1
    assign push_valid = accept;
    assign push_data  = rd_rsp;
  end else begin : g_pipe
    logic [LATENCY-2:0] v_q, v_d;
    imem_rsp_t          d_q [LATENCY-1];
    imem_rsp_t          d_d [LATENCY-1];

    // Shift valids and data one stage per cycle; flush drops all valids.
    always_comb begin
      v_d[0] = accept;
      d_d[0] = rd_rsp;
      for (int i = 1; i < LATENCY-1; i++) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
      end
      if (flush) v_d = '0;
    end

    // Stage registers; only the valids need reset.
    always_ff @(posedge clk) begin
      if (reset) v_q <= '0;
      else       v_q <= v_d;
      for (int i = 0; i < LATENCY-1; i++) d_q[i] <= d_d[i];
    end

    assign push_valid = v_q[LATENCY-2];
    assign push_data  = d_q[LATENCY-2];
  end

  imem_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push_valid && !flush),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: one instance at LATENCY=1 (index 0)
// and one at LATENCY=3 (index 1), each with its own stimulus lanes.
module tb_imem_fetch_unit;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]       flush, ld_valid, ld_ready;
  logic [1:0][31:0] req_addr, rsp_inst, ld_data;
  logic [1:0][2:0]  rsp_fault;
  logic [1:0][7:0]  ld_addr;

  int n_vec = 0;
  int n_err = 0;
  int pop_cnt [2];

  logic [34:0] exp_q0[$];
  logic [34:0] exp_q1[$];

  logic [31:0] words [4] = '{32'h34090005, 32'h340a0005, 32'h01494824, 32'h08000005};

`ifdef IMEM_PARITY_EN
  localparam logic [2:0] PAR_FAULT = 3'b100;
`else
  localparam logic [2:0] PAR_FAULT = 3'b000;
`endif

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  imem_fetch_unit #(.LATENCY(1)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_inst(rsp_inst[0]),
    .rsp_fault(rsp_fault[0]), .flush(flush[0]),
    .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]), .ld_addr(ld_addr[0]),
    .ld_data(ld_data[0])
  );

  imem_fetch_unit #(.LATENCY(3)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_inst(rsp_inst[1]),
    .rsp_fault(rsp_fault[1]), .flush(flush[1]),
    .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]), .ld_addr(ld_addr[1]),
    .ld_data(ld_data[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [34:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response popped is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (!flush[0] && rsp_valid[0] && rsp_ready[0]) begin
        pop_cnt[0]++;
        if (exp_q0.size() == 0) chk("rsp0_unexpected", 64'(exp_q0.size()), 64'd1);
        else chk("rsp0", {rsp_fault[0], rsp_inst[0]}, exp_q0.pop_front());
      end
      if (!flush[1] && rsp_valid[1] && rsp_ready[1]) begin
        pop_cnt[1]++;
        if (exp_q1.size() == 0) chk("rsp1_unexpected", 64'(exp_q1.size()), 64'd1);
        else chk("rsp1", {rsp_fault[1], rsp_inst[1]}, exp_q1.pop_front());
      end
    end
  end

  // Driver: offer one request until accepted (bounded), record its expectation.
  task automatic send(input int d, input logic [31:0] addr, input logic [34:0] e);
    bit done = 1'b0;
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        done = 1'b1;
        push_exp(d, e);
      end
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0;
    chk($sformatf("send%0d_%0h_accepted", d, addr), 64'(done), 64'd1);
  endtask

  // Driver: one program-load write (bounded wait for ld_ready).
  task automatic load(input int d, input logic [7:0] idx, input logic [31:0] data);
    bit done = 1'b0;
    ld_valid[d] = 1'b1;
    ld_addr[d]  = idx;
    ld_data[d]  = data;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (ld_ready[d]) done = 1'b1;
      @(posedge clk); #1;
    end
    ld_valid[d] = 1'b0;
    chk($sformatf("load%0d_%0d", d, idx), 64'(done), 64'd1);
  endtask

  initial begin
    int acc;
    reset = 1'b1;
    req_valid = '0; rsp_ready = '0; flush = '0; ld_valid = '0;
    req_addr = '0; ld_addr = '0; ld_data = '0;
    pop_cnt[0] = 0; pop_cnt[1] = 0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready0", 64'(req_ready[0]), 64'd0);
    chk("rst_req_ready1", 64'(req_ready[1]), 64'd0);
    chk("rst_ld_ready0",  64'(ld_ready[0]),  64'd0);
    chk("rst_ld_ready1",  64'(ld_ready[1]),  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid0", 64'(rsp_valid[0]), 64'd0);
    chk("rst_rsp_out0",   {rsp_fault[0], rsp_inst[0]}, 64'd0);
    chk("rst_rsp_valid1", 64'(rsp_valid[1]), 64'd0);
    chk("rst_rsp_out1",   {rsp_fault[1], rsp_inst[1]}, 64'd0);
    chk("post_rst_req_ready0", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;

    // Program both instances
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) load(d, 8'(i), words[i]);

    // LATENCY=1 back-to-back fetch: one response per cycle, first one cycle after accept
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[0] = 32'(i * 4);
      @(negedge clk);
      chk($sformatf("t1_req_ready_%0d", i), 64'(req_ready[0]), 64'd1);
      chk($sformatf("t1_rsp_valid_%0d", i), 64'(rsp_valid[0]), 64'(i > 0));
      if (req_ready[0]) push_exp(0, {3'b000, words[i]});
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_last_valid", 64'(rsp_valid[0]), 64'd1);
    tick(3);
    chk("t1_pops", 64'(pop_cnt[0]), 64'd4);
    chk("t1_drained", 64'(exp_q0.size()), 64'd0);

    // LATENCY=3 under backpressure: exactly FIFO_DEPTH=4 accepts, then stall
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      req_addr[1] = 32'(acc * 4);
      @(negedge clk);
      if (req_ready[1]) begin
        push_exp(1, {3'b000, words[acc & 3]});
        acc++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t2_req_ready_low", 64'(req_ready[1]), 64'd0);
    chk("t2_accepts", 64'(acc), 64'd4);
    chk("t2_head_held", {rsp_fault[1], rsp_inst[1]}, {29'd0, 3'b000, words[0]});
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    tick(8);
    chk("t2_pops", 64'(pop_cnt[1]), 64'd4);
    chk("t2_drained", 64'(exp_q1.size()), 64'd0);

    // Fault decode on the LATENCY=1 instance
    send(0, 32'h6,   {3'b001, 32'h0});
    send(0, 32'h400, {3'b010, 32'h0});
    send(0, 32'h402, {3'b011, 32'h0});
    tick(3);
    chk("t3_pops", 64'(pop_cnt[0]), 64'd7);
    chk("t3_drained", 64'(exp_q0.size()), 64'd0);

    // Flush with one response buffered and two in flight (LATENCY=3)
    rsp_ready[1] = 1'b0;
    send(1, 32'h0, {3'b000, words[0]});
    send(1, 32'h4, {3'b000, words[1]});
    send(1, 32'h8, {3'b000, words[2]});
    flush[1] = 1'b1;
    exp_q1.delete();
    @(negedge clk);
    chk("t4_valid_at_flush", 64'(rsp_valid[1]), 64'd1);
    chk("t4_req_ready_flush", 64'(req_ready[1]), 64'd0);
    @(posedge clk); #1;
    flush[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t4_valid_after_%0d", c), 64'(rsp_valid[1]), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t4_ld_ready_idle", 64'(ld_ready[1]), 64'd1);
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    send(1, 32'h8, {3'b000, 32'h01494824});
    tick(5);
    chk("t4_pops", 64'(pop_cnt[1]), 64'd5);
    chk("t4_drained", 64'(exp_q1.size()), 64'd0);

    // Reset with two responses outstanding (LATENCY=1, FIFO full)
    rsp_ready[0] = 1'b0;
    send(0, 32'h4, {3'b000, words[1]});
    send(0, 32'h8, {3'b000, words[2]});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("t5_full_%0d", c), 64'(req_ready[0]), 64'd0);
      chk($sformatf("t5_hold_%0d", c), {rsp_fault[0], rsp_inst[0]}, {29'd0, 3'b000, words[1]});
      @(posedge clk); #1;
    end
    reset = 1'b1;
    exp_q0.delete();
    @(negedge clk);
    chk("t5_rst_req_ready", 64'(req_ready[0]), 64'd0);
    chk("t5_rst_ld_ready",  64'(ld_ready[0]),  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("t5_rsp_out",   {rsp_fault[0], rsp_inst[0]}, 64'd0);
    chk("t5_req_ready", 64'(req_ready[0]), 64'd1);
    chk("t5_ld_ready_outstanding0", 64'(ld_ready[0]), 64'd1);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    send(0, 32'h0, {3'b000, 32'h34090005});
    tick(3);
    chk("t5_pops", 64'(pop_cnt[0]), 64'd8);
    chk("t5_drained", 64'(exp_q0.size()), 64'd0);

    // Corrupt stored word 1 (data bit 0) and fetch it back
    dut0.mem_q[1][0] = ~dut0.mem_q[1][0];
    send(0, 32'h4, {PAR_FAULT, 32'h340a0004});
    tick(3);
    chk("t6_pops", 64'(pop_cnt[0]), 64'd9);
    chk("t6_drained", 64'(exp_q0.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
